// File: rtl/traffic_light_ctrl.sv
// Highway / country-road traffic light controller with a tick prescaler and per-phase countdown.
// Highway holds green until a country vehicle has been latched; country green ends early when the road empties.
module traffic_light_ctrl #(
   parameter int unsigned TICK_DIV = 10,
   parameter int unsigned T_HG     = 59,
   parameter int unsigned T_Y      = 9,
   parameter int unsigned T_AR     = 1,
   parameter int unsigned T_CG     = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sensor,
   output logic [2:0] hw_light,
   output logic [2:0] cr_light,
   output logic [6:0] time_left,
   output logic       phase_done,
   output logic [2:0] state_o
);

   localparam int unsigned PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

   localparam logic [2:0] LampR = 3'b100;
   localparam logic [2:0] LampY = 3'b010;
   localparam logic [2:0] LampG = 3'b001;

   typedef enum logic [2:0] {
      StHg  = 3'd0,
      StHy  = 3'd1,
      StAr1 = 3'd2,
      StCg  = 3'd3,
      StCy  = 3'd4,
      StAr2 = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [6:0]    time_q, time_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          sens_lat_q, sens_lat_d;
   logic [2:0]    hw_q, hw_d, cr_q, cr_d;
   logic          tick;
   logic          time_zero;

   function automatic logic [6:0] phase_len(state_e s);
      case (s)
         StHg:         phase_len = 7'(T_HG);
         StHy, StCy:   phase_len = 7'(T_Y);
         StAr1, StAr2: phase_len = 7'(T_AR);
         StCg:         phase_len = 7'(T_CG);
         default:      phase_len = 7'(T_HG);
      endcase
   endfunction

   assign tick      = (presc_q == PW'(TICK_DIV));
   assign time_zero = (time_q == 7'd0);
   assign presc_d   = tick ? '0 : presc_q + PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StHg;
         time_q     <= 7'(T_HG);
         presc_q    <= '0;
         sens_lat_q <= 1'b0;
         hw_q       <= LampG;
         cr_q       <= LampR;
      end else begin
         state_q    <= state_d;
         time_q     <= time_d;
         presc_q    <= presc_d;
         sens_lat_q <= sens_lat_d;
         hw_q       <= hw_d;
         cr_q       <= cr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StHg:    if (tick && time_zero && sens_lat_q) state_d = StHy;
         StHy:    if (tick && time_zero) state_d = StAr1;
         StAr1:   if (tick && time_zero) state_d = StCg;
         StCg:    if (tick && (time_zero || !sensor)) state_d = StCy;
         StCy:    if (tick && time_zero) state_d = StAr2;
         StAr2:   if (tick && time_zero) state_d = StHg;
         // Unused codes recover to highway green without waiting for a tick.
         default: state_d = StHg;
      endcase

      time_d = time_q;
      if (state_d != state_q) begin
         time_d = phase_len(state_d);
      end else if (tick && !time_zero) begin
         time_d = time_q - 7'd1;
      end

      // Entering country green consumes the request; a same-cycle set is dropped.
      sens_lat_d = sens_lat_q;
      if (state_d == StCg && state_q != StCg) begin
         sens_lat_d = 1'b0;
      end else if (sensor && state_q != StCg) begin
         sens_lat_d = 1'b1;
      end
   end

   always_comb begin
      hw_d = LampR;
      cr_d = LampR;
      case (state_d)
         StHg:    hw_d = LampG;
         StHy:    hw_d = LampY;
         StCg:    cr_d = LampG;
         StCy:    cr_d = LampY;
         default: ;
      endcase
   end

   assign phase_done = tick && (state_d != state_q) && !rst;
   assign hw_light   = hw_q;
   assign cr_light   = cr_q;
   assign time_left  = time_q;
   assign state_o    = state_q;

endmodule
